skid_pipeline: RTL
==================

SKID_PIPELINE -- requirements
Module: skid_pipeline

Interface
REQ-001 WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 DEPTH, default 2: number of cascaded skid stages, legal range 1..8.
REQ-003 clk  input  1: single clock; one clock; reset is synchronous and active-high; all state changes on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 flush  input  1: synchronous drop of all held data.
REQ-006 in_valid  input  1: upstream offers in_data.
REQ-007 in_ready  output  1: pipeline can accept; driven only from registers, never combinationally from out_ready.
REQ-008 in_data  input  WIDTH: upstream payload.
REQ-009 out_valid  output  1: out_data is valid.
REQ-010 out_ready  input  1: downstream accepts.
REQ-011 out_data  output  WIDTH: head-of-pipeline payload.
REQ-012 count  output  $clog2(2*DEPTH+1): number of words held, range 0..2*DEPTH.

Function
REQ-013 Transfer rules: input fire = in_valid & in_ready; output fire = out_valid & out_ready; only fires move data.
REQ-014 Each stage SHALL have three states: EMPTY, BUSY (main register valid) and FULL (main and skid registers valid).
REQ-015 Stage in_ready = (state != FULL); stage out_valid = (state != EMPTY); stage out_data = main register.
REQ-016 EMPTY: in fire -> BUSY, main <= in.
REQ-017 BUSY: in fire only -> FULL, skid <= in; in and out fire -> BUSY, main <= in; out fire only -> EMPTY.
REQ-018 FULL: out fire -> BUSY, main <= skid; in fire is impossible.
REQ-019 Stage k out_valid/out_ready/out_data SHALL connect to stage k+1 in_valid/in_ready/in_data; stage 0 faces the inputs; stage DEPTH-1 faces the outputs.
REQ-020 Latency from input fire into an empty pipeline to out_valid SHALL be DEPTH cycles.
REQ-021 Sustained throughput with out_ready held high SHALL be one word per cycle, with no bubbles.
REQ-022 Ordering SHALL be strict FIFO; no word is duplicated or dropped except by flush or rst.
REQ-023 Capacity SHALL be 2*DEPTH words; in_ready falls only when stage 0 is FULL.
REQ-024 count SHALL be registered: next = count + in fire - out fire; simultaneous fires leave it unchanged; it never wraps.
REQ-025 flush cycle: in_ready=0 and out_valid=0; next edge -> all stages EMPTY, count=0.
REQ-026 flush asserted together with in_valid SHALL NOT accept the word.
REQ-027 out_data while out_valid=0 SHALL be don't-care; the bench SHALL NOT check it.
REQ-028 out_valid SHALL stay high, with out_data stable, until an out fire occurs.

Reset
REQ-029 When rst=1 at an edge: all stages EMPTY, count=0, data registers 0; rst SHALL have priority over flush and all fires.
REQ-030 After reset: out_valid=0, in_ready=1, count=0.
REQ-031 rst asserted mid-transfer SHALL discard all held words; the first cycle after release behaves as empty.

Structure
REQ-032 Package skid_pipeline_pkg SHALL hold the stage state enum (EMPTY, BUSY, FULL) and the count-width function.
REQ-033 Sub-module skid_stage SHALL hold one stage (WIDTH parameter, clk, rst, flush, in/out handshake); the top SHALL instantiate DEPTH copies in a generate loop and keep count.
REQ-034 The design SHALL have no combinational path from out_ready to in_ready, checked by lint/STA.

Verification
REQ-035 WIDTH=32, DEPTH=2: write 0x1 at cycle 0 with out_ready=1 -> out_valid at cycle 2 with out_data=0x1, count 1 then 0.
REQ-036 Stream 0..99 with in_valid and out_ready held high -> 100 outputs in order, one per cycle after 2-cycle latency, in_ready never low.
REQ-037 out_ready=0, push until stall -> exactly 4 words accepted, count=4, in_ready=0; then out_ready=1 -> words 1..4 drain in order.
REQ-038 Fill 3 words then assert flush for 1 cycle with in_valid=1, in_data=0xAA -> next cycle count=0, out_valid=0, 0xAA never appears.
REQ-039 rst pulse while count=3 -> next cycle count=0, out_valid=0, in_ready=1; post-reset word 0x55 emerges alone.
REQ-040 Random valid/ready at 50%, 10k words, DEPTH in {1,4,8} -> scoreboard match, count equals model every cycle, no ready combinational-path assertion failure.

Source files
------------

// File: rtl/skid_pipeline_pkg.sv
// Shared types and helpers for the cascaded skid pipeline.
// Stage state encoding and occupancy counter width.
package skid_pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } stage_state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One skid buffer stage: main register plus skid register.
// Ready and valid are pure decodes of the state register.
module skid_stage
  import skid_pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_t     state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/skid_pipeline.sv
// DEPTH cascaded skid stages with a registered occupancy count.
// Flush masks both handshakes so nothing moves in the flush cycle.
module skid_pipeline
  import skid_pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic             v [DEPTH+1];
  logic             r [DEPTH+1];
  logic [WIDTH-1:0] d [DEPTH+1];
  logic             in_fire;
  logic             out_fire;
  logic [CW-1:0]    count_q;

  assign v[0]      = in_valid & ~flush;
  assign d[0]      = in_data;
  assign r[DEPTH]  = out_ready;
  assign in_ready  = r[0] & ~flush;
  assign out_valid = v[DEPTH] & ~flush;
  assign out_data  = d[DEPTH];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign count     = count_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (v[k]),
      .in_ready (r[k]),
      .in_data  (d[k]),
      .out_valid(v[k+1]),
      .out_ready(r[k+1]),
      .out_data (d[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else if (in_fire && !out_fire) begin
      count_q <= count_q + CW'(1);
    end else if (out_fire && !in_fire) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule
